// File: rtl/uart_event_bridge_if.sv
// Signal bundle between the UART RX/TX pair, the DVS accelerator and uart_event_bridge.
// master = environment side (UART + accelerator), slave = the bridge.
interface uart_event_bridge_if #(
    parameter int COORD_W   = 9,
    parameter int BIN_W     = 3,
    parameter int GESTURE_W = 2
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [COORD_W-1:0]   evt_x;
    logic [COORD_W-1:0]   evt_y;
    logic                 evt_pol;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [GESTURE_W-1:0] gesture;
    logic                 gesture_valid;
    logic [BIN_W-1:0]     current_bin;
    logic                 parse_err;
    logic                 evt_drop;

    modport master (
        output rx_data, rx_valid, tx_ready, evt_ready, gesture, gesture_valid, current_bin,
        input  tx_data, tx_valid, evt_x, evt_y, evt_pol, evt_valid, parse_err, evt_drop
    );
    modport slave (
        input  rx_data, rx_valid, tx_ready, evt_ready, gesture, gesture_valid, current_bin,
        output tx_data, tx_valid, evt_x, evt_y, evt_pol, evt_valid, parse_err, evt_drop
    );
endinterface

// File: rtl/uart_event_bridge.sv
// UART byte protocol engine: 5-byte event packets into an event FIFO, command/gesture bytes out via a TX FIFO.
// Optional macro UART_BRIDGE_STATS_EN adds a saturating drop counter read (and cleared) by command 0xFD.
module uart_event_bridge #(
    parameter int COORD_W           = 9,
    parameter int BIN_W             = 3,
    parameter int GESTURE_W         = 2,
    parameter int EVT_FIFO_DEPTH    = 8,
    parameter int TX_FIFO_DEPTH     = 4,
    parameter int RX_TIMEOUT_CYCLES = 1200
) (
    input logic clk,
    input logic rst,
    uart_event_bridge_if.slave bus
);
    localparam int EAW = $clog2(EVT_FIFO_DEPTH);
    localparam int TAW = $clog2(TX_FIFO_DEPTH);
    localparam int TMW = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam int HIW = COORD_W - 8;

    typedef enum logic [2:0] {S_HDR, S_XL, S_YH, S_YL, S_POL} state_t;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               pol;
    } evt_t;

    state_t         r_state, w_next;
    logic [TMW-1:0] r_tmo;
    logic [HIW-1:0] r_xhi, r_yhi;
    logic [7:0]     r_xlo, r_ylo;
    logic           r_parse_err, r_evt_drop;
    logic           w_hi_ok, w_err, w_done, w_cmd_raw, w_cmd, w_tmo_hit;
    logic [7:0]     w_resp;
    evt_t           w_pkt;
`ifdef UART_BRIDGE_STATS_EN
    logic [7:0]     r_drop_cnt;
    logic           w_stats_cmd;
`endif

    assign w_hi_ok   = (bus.rx_data >> HIW) == 8'd0;
    assign w_tmo_hit = (r_state != S_HDR) && !bus.rx_valid && (r_tmo == TMW'(RX_TIMEOUT_CYCLES - 1));
    assign w_pkt     = {r_xhi, r_xlo, r_yhi, r_ylo, bus.rx_data[0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HDR;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_done    = 1'b0;
        w_cmd_raw = 1'b0;
        w_resp    = 8'h00;
`ifdef UART_BRIDGE_STATS_EN
        w_stats_cmd = 1'b0;
`endif
        if (bus.rx_valid) begin
            unique case (r_state)
                S_HDR: begin
                    if (bus.rx_data == 8'hFF) begin
                        w_cmd_raw = 1'b1;
                        w_resp    = 8'h55;
                    end else if (bus.rx_data == 8'hFE) begin
                        w_cmd_raw = 1'b1;
                        w_resp    = {4'hB, 4'(bus.current_bin)};
                    end
`ifdef UART_BRIDGE_STATS_EN
                    else if (bus.rx_data == 8'hFD) begin
                        w_cmd_raw   = 1'b1;
                        w_stats_cmd = 1'b1;
                        w_resp      = r_drop_cnt;
                    end
`endif
                    else if (w_hi_ok) w_next = S_XL;
                    else              w_err  = 1'b1;
                end
                S_XL: w_next = S_YH;
                S_YH: begin
                    if (w_hi_ok) w_next = S_YL;
                    else begin
                        w_err  = 1'b1;
                        w_next = S_HDR;
                    end
                end
                S_YL: w_next = S_POL;
                S_POL: begin
                    w_done = 1'b1;
                    w_next = S_HDR;
                end
                default: w_next = S_HDR;
            endcase
        end else if (w_tmo_hit) begin
            w_next = S_HDR;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xhi <= '0;
            r_xlo <= '0;
            r_yhi <= '0;
            r_ylo <= '0;
        end else if (bus.rx_valid) begin
            unique case (r_state)
                S_HDR:   r_xhi <= bus.rx_data[HIW-1:0];
                S_XL:    r_xlo <= bus.rx_data;
                S_YH:    r_yhi <= bus.rx_data[HIW-1:0];
                S_YL:    r_ylo <= bus.rx_data;
                default: ;
            endcase
        end
    end

    // Idle counter only runs mid-packet; any received byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || bus.rx_valid || r_state == S_HDR || w_tmo_hit) r_tmo <= '0;
        else                                                       r_tmo <= r_tmo + TMW'(1);
    end

    // ---------------- event FIFO (fall-through) ----------------
    evt_t           r_emem [EVT_FIFO_DEPTH];
    logic [EAW-1:0] r_ewp, r_erp;
    logic [EAW:0]   r_ecnt;
    logic           w_efull, w_epush, w_epop, w_drop;
    evt_t           w_ehead;

    assign w_efull = r_ecnt == (EAW+1)'(EVT_FIFO_DEPTH);
    assign w_epush = w_done && !w_efull;
    assign w_drop  = w_done && w_efull;
    assign w_epop  = bus.evt_valid && bus.evt_ready;
    assign w_ehead = r_emem[r_erp];

    always_ff @(posedge clk) begin
        if (w_epush) r_emem[r_ewp] <= w_pkt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ewp  <= '0;
            r_erp  <= '0;
            r_ecnt <= '0;
        end else begin
            if (w_epush) r_ewp <= r_ewp + EAW'(1);
            if (w_epop)  r_erp <= r_erp + EAW'(1);
            case ({w_epush, w_epop})
                2'b10:   r_ecnt <= r_ecnt + (EAW+1)'(1);
                2'b01:   r_ecnt <= r_ecnt - (EAW+1)'(1);
                default: ;
            endcase
        end
    end

    assign bus.evt_valid = r_ecnt != '0;
    assign bus.evt_x     = bus.evt_valid ? w_ehead.x   : '0;
    assign bus.evt_y     = bus.evt_valid ? w_ehead.y   : '0;
    assign bus.evt_pol   = bus.evt_valid ? w_ehead.pol : 1'b0;

    // ---------------- TX FIFO with gesture-first arbitration ----------------
    logic [7:0]     r_tmem [TX_FIFO_DEPTH];
    logic [TAW-1:0] r_twp, r_trp;
    logic [TAW:0]   r_tcnt;
    logic           r_pend_vld;
    logic [7:0]     r_pend_data;
    logic           w_tfull, w_twr_req, w_tpush, w_tpop;
    logic [7:0]     w_twr_data;

    assign w_cmd   = w_cmd_raw && !r_pend_vld;
    assign w_tfull = r_tcnt == (TAW+1)'(TX_FIFO_DEPTH);
    assign w_tpush = w_twr_req && !w_tfull;
    assign w_tpop  = bus.tx_valid && bus.tx_ready;

    always_comb begin
        w_twr_req  = 1'b0;
        w_twr_data = 8'h00;
        if (bus.gesture_valid) begin
            w_twr_req  = 1'b1;
            w_twr_data = {4'hA, 4'(bus.gesture)};
        end else if (r_pend_vld) begin
            w_twr_req  = 1'b1;
            w_twr_data = r_pend_data;
        end else if (w_cmd) begin
            w_twr_req  = 1'b1;
            w_twr_data = w_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tpush) r_tmem[r_twp] <= w_twr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_twp       <= '0;
            r_trp       <= '0;
            r_tcnt      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
        end else begin
            if (w_tpush) r_twp <= r_twp + TAW'(1);
            if (w_tpop)  r_trp <= r_trp + TAW'(1);
            case ({w_tpush, w_tpop})
                2'b10:   r_tcnt <= r_tcnt + (TAW+1)'(1);
                2'b01:   r_tcnt <= r_tcnt - (TAW+1)'(1);
                default: ;
            endcase
            // A response that lost to a gesture waits here; it retries every gesture-free cycle.
            if (bus.gesture_valid && w_cmd) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= w_resp;
            end else if (!bus.gesture_valid && r_pend_vld && !w_tfull) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    assign bus.tx_valid = r_tcnt != '0;
    assign bus.tx_data  = bus.tx_valid ? r_tmem[r_trp] : 8'h00;

`ifdef UART_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                r_drop_cnt <= 8'h00;
        else if (w_stats_cmd && w_cmd)          r_drop_cnt <= {7'd0, w_drop};
        else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parse_err <= 1'b0;
            r_evt_drop  <= 1'b0;
        end else begin
            r_parse_err <= w_err;
            r_evt_drop  <= w_drop;
        end
    end

    assign bus.parse_err = r_parse_err;
    assign bus.evt_drop  = r_evt_drop;
endmodule

// File: tb/tb_uart_event_bridge.sv
// Scoreboard bench for uart_event_bridge: a byte-stream reference model predicts events/TX bytes,
// a negedge monitor pops and compares whatever the DUT hands out.
module tb_uart_event_bridge;
    localparam int CW = 9, BW = 3, GW = 2, EDEPTH = 8, TDEPTH = 4, TMO = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_event_bridge_if #(.COORD_W(CW), .BIN_W(BW), .GESTURE_W(GW)) bus ();

    uart_event_bridge #(
        .COORD_W(CW), .BIN_W(BW), .GESTURE_W(GW),
        .EVT_FIFO_DEPTH(EDEPTH), .TX_FIFO_DEPTH(TDEPTH), .RX_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {int x; int y; int pol;} ev_t;
    ev_t evq[$];
    int  txq[$];
    int  vec = 0, bad = 0;
    int  m_pos, m_xhi, m_xlo, m_yhi, m_ylo, m_idle, m_pend_v, m_pend, m_dropcnt;
    int  exp_err, exp_drop, obs_err, obs_drop, obs_epop;
    ev_t mon_e;
    int  mon_b;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_idle = 0; m_pend_v = 0; m_pend = 0; m_dropcnt = 0;
        m_xhi = 0; m_xlo = 0; m_yhi = 0; m_ylo = 0;
        evq.delete(); txq.delete();
        exp_err = obs_err; exp_drop = obs_drop;
    endtask

    // Byte-stream reference: packet position 0..4, FIFOs as queues with depth limits.
    task automatic model_step(input bit rxv, input int d, input bit gv, input int g, input int bin);
        int resp = 0;
        bit cmd = 0, stats = 0, done = 0;
        if (rxv) begin
            m_idle = 0;
            case (m_pos)
                0: begin
                    if (d == 255) begin cmd = 1; resp = 'h55; end
                    else if (d == 254) begin cmd = 1; resp = 'hB0 + bin; end
`ifdef UART_BRIDGE_STATS_EN
                    else if (d == 253) begin cmd = 1; stats = 1; resp = m_dropcnt; end
`endif
                    else if ((d >> (CW - 8)) == 0) begin m_xhi = d; m_pos = 1; end
                    else exp_err++;
                end
                1: begin m_xlo = d; m_pos = 2; end
                2: begin
                    if ((d >> (CW - 8)) == 0) begin m_yhi = d; m_pos = 3; end
                    else begin exp_err++; m_pos = 0; end
                end
                3: begin m_ylo = d; m_pos = 4; end
                default: begin done = 1; m_pos = 0; end
            endcase
        end else if (m_pos != 0) begin
            m_idle++;
            if (m_idle == TMO) begin m_pos = 0; m_idle = 0; exp_err++; end
        end
        if (done) begin
            if (evq.size() >= EDEPTH) begin
                exp_drop++;
                if (m_dropcnt < 255) m_dropcnt++;
            end else evq.push_back('{x: m_xhi * 256 + m_xlo, y: m_yhi * 256 + m_ylo, pol: d & 1});
        end
        if (cmd && m_pend_v) cmd = 0;
        if (cmd && stats) m_dropcnt = 0;
        if (gv) begin
            if (txq.size() < TDEPTH) txq.push_back('hA0 + g);
            if (cmd) begin m_pend_v = 1; m_pend = resp; end
        end else if (m_pend_v) begin
            if (txq.size() < TDEPTH) begin txq.push_back(m_pend); m_pend_v = 0; end
        end else if (cmd) begin
            if (txq.size() < TDEPTH) txq.push_back(resp);
        end
    endtask

    task automatic cyc(input bit rxv, input int d, input bit gv = 0, input int g = 0);
        bus.rx_valid = rxv; bus.rx_data = 8'(d);
        bus.gesture_valid = gv; bus.gesture = GW'(g);
        model_step(rxv, d, gv, g, int'(bus.current_bin));
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.gesture_valid = 1'b0;
    endtask

    task automatic send_pkt(input int x, input int y, input int pol);
        cyc(1, x >> 8); cyc(1, x & 255); cyc(1, y >> 8); cyc(1, y & 255); cyc(1, pol);
    endtask

    task automatic drain_check(input string nm);
        int n = 0;
        bus.evt_ready = 1'b1; bus.tx_ready = 1'b1;
        while ((evq.size() != 0 || txq.size() != 0 || m_pend_v != 0) && n < 300) begin
            cyc(0, 0); n++;
        end
        repeat (3) cyc(0, 0);
        chk({nm, " events left"}, evq.size(), 0);
        chk({nm, " tx bytes left"}, txq.size(), 0);
        chk({nm, " parse_err pulses"}, obs_err, exp_err);
        chk({nm, " evt_drop pulses"}, obs_drop, exp_drop);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.evt_valid && bus.evt_ready) begin
                vec++; obs_epop++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL evt_unexpected: got x=%0h y=%0h pol=%0d, expected none", bus.evt_x, bus.evt_y, bus.evt_pol);
                end else begin
                    mon_e = evq.pop_front();
                    if (int'(bus.evt_x) != mon_e.x || int'(bus.evt_y) != mon_e.y || int'(bus.evt_pol) != mon_e.pol) begin
                        bad++;
                        $display("FAIL evt_data: got x=%0h y=%0h pol=%0d, expected x=%0h y=%0h pol=%0d",
                                 bus.evt_x, bus.evt_y, bus.evt_pol, mon_e.x, mon_e.y, mon_e.pol);
                    end
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                vec++;
                if (txq.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got %0h, expected none", bus.tx_data);
                end else begin
                    mon_b = txq.pop_front();
                    if (int'(bus.tx_data) != mon_b) begin
                        bad++;
                        $display("FAIL tx_byte: got %0h, expected %0h", bus.tx_data, mon_b);
                    end
                end
            end
            if (bus.parse_err) obs_err++;
            if (bus.evt_drop)  obs_drop++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, p0, r;
        obs_err = 0; obs_drop = 0; obs_epop = 0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.gesture = 0; bus.gesture_valid = 0;
        bus.current_bin = 0; bus.tx_ready = 0; bus.evt_ready = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; model_reset();

        chk("rst tx_valid", bus.tx_valid, 0);
        chk("rst evt_valid", bus.evt_valid, 0);
        chk("rst parse_err", bus.parse_err, 0);
        chk("rst evt_drop", bus.evt_drop, 0);
        chk("rst tx_data", bus.tx_data, 0);
        chk("rst evt_x", bus.evt_x, 0);
        chk("rst evt_y", bus.evt_y, 0);
        chk("rst evt_pol", bus.evt_pol, 0);

        // Basic packet with latency check.
        bus.evt_ready = 1; bus.tx_ready = 1;
        cyc(1, 'h01); cyc(1, 'h3F); cyc(1, 'h00); cyc(1, 'hA0);
        chk("pkt evt_valid before POL", bus.evt_valid, 0);
        cyc(1, 'h01);
        chk("pkt evt_valid after POL", bus.evt_valid, 1);
        chk("pkt evt_x", bus.evt_x, 'h13F);
        chk("pkt evt_y", bus.evt_y, 'h0A0);
        chk("pkt evt_pol", bus.evt_pol, 1);
        drain_check("pkt");

        // Echo and status commands.
        bus.current_bin = 3'd5;
        cyc(1, 'hFF);
        chk("echo tx_data", bus.tx_data, 'h55);
        cyc(1, 'hFE);
        drain_check("cmd");

        // Fill event FIFO, one packet over.
        bus.evt_ready = 0;
        p0 = obs_drop;
        for (int i = 0; i < EDEPTH + 1; i++) send_pkt($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
        cyc(0, 0); cyc(0, 0);
        chk("fill evt_drop count", obs_drop - p0, 1);
        p0 = obs_epop;
        drain_check("fill");
        chk("fill drained events", obs_epop - p0, EDEPTH);
`ifdef UART_BRIDGE_STATS_EN
        cyc(1, 'hFD);
        chk("stats first read", bus.tx_data, 'h01);
        drain_check("stats1");
        cyc(1, 'hFD);
        chk("stats second read", bus.tx_data, 'h00);
        drain_check("stats2");
`endif

        // Inter-byte timeout.
        cyc(1, 'h00); cyc(1, 'h12);
        e0 = obs_err;
        repeat (TMO - 1) cyc(0, 0);
        chk("timeout no early err", obs_err - e0, 0);
        cyc(0, 0); cyc(0, 0);
        chk("timeout err pulse", obs_err - e0, 1);
        send_pkt('h0AB, 'h1CD, 0);
        drain_check("timeout");
        e0 = obs_err;
        cyc(1, 'h80); cyc(0, 0);
        chk("hdr 0x80 err", obs_err - e0, 1);
        drain_check("badhdr");

        // Gesture/command collision with transmitter stalled.
        bus.tx_ready = 0;
        cyc(1, 'hFF, 1, 2);
        chk("collide tx_valid", bus.tx_valid, 1);
        chk("collide head", bus.tx_data, 'hA2);
        repeat (3) cyc(0, 0);
        chk("collide head held", bus.tx_data, 'hA2);
        drain_check("collide");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.evt_ready = ($urandom % 4) != 0;
            bus.tx_ready = ($urandom % 3) != 0;
            bus.current_bin = BW'($urandom);
            case (m_pos)
                0: begin
                    r = $urandom % 8;
                    r = (r == 0) ? 'hFF : (r == 1) ? 'hFE : (r == 2) ? 'hFD : (r == 3) ? int'($urandom % 256) : int'($urandom % 2);
                end
                2: r = (($urandom % 8) == 0) ? int'($urandom % 256) : int'($urandom % 2);
                default: r = $urandom % 256;
            endcase
            cyc(($urandom % 2) == 0, r, ($urandom % 6) == 0, $urandom % 4);
        end
        drain_check("random");

        // Reset in the middle of traffic.
        bus.evt_ready = 0; bus.tx_ready = 0;
        send_pkt('h055, 'h066, 1);
        cyc(1, 'hFF, 1, 1);
        cyc(1, 'h01); cyc(1, 'h3F);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst evt_valid", bus.evt_valid, 0);
        chk("midrst tx_valid", bus.tx_valid, 0);
        rst = 1'b0; model_reset();
        bus.evt_ready = 1;
        send_pkt('h1FF, 'h001, 1);
        drain_check("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
